ysyx_22040750_mem_wb_reg: RTL and testbench

Pipeline register between the MEM stage and register-file/CSR writeback. Accepts one retiring instruction per cycle under valid/allowin handshake. Performs load-data alignment and sign/zero extension, then selects the writeback value. Drives regfile/CSR write enables, a forwarding port toward ID, and a one-cycle commit pulse plus retire counter for difftest.

---
 rtl/ysyx_22040750_mem_wb_reg_pkg.sv | 20 ++
 rtl/ysyx_22040750_load_fmt.sv | 46 ++++
 rtl/ysyx_22040750_mem_wb_reg.sv | 134 +++++++++++++
 tb/tb_ysyx_22040750_mem_wb_reg.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040750_mem_wb_reg_pkg.sv
// Shared constants for the MEM/WB stage: writeback source encodings,
// load byte-strobe masks and the default datapath widths.
package ysyx_22040750_mem_wb_reg_pkg;

  localparam int MWB_XLEN = 64;
  localparam int MWB_PC_W = 32;

  // Writeback source select. Bit 1 set means "load result" regardless of bit 0.
  localparam logic [1:0] REGIN_ALU     = 2'b00;
  localparam logic [1:0] REGIN_CSR     = 2'b01;
  localparam int         REGIN_MEM_BIT = 1;

  // Byte masks carried in rstrb[7:0]; rstrb[8] requests sign extension.
  localparam logic [7:0] RSTRB_B        = 8'h01;
  localparam logic [7:0] RSTRB_H        = 8'h03;
  localparam logic [7:0] RSTRB_W        = 8'h0F;
  localparam logic [7:0] RSTRB_D        = 8'hFF;
  localparam int         RSTRB_SIGN_BIT = 8;

endpackage

// File: rtl/ysyx_22040750_load_fmt.sv
// Combinational load formatter: shifts the 8-byte-aligned load word down by
// the byte offset, keeps the bytes named by the strobe mask and sign- or
// zero-extends the result to XLEN.
module ysyx_22040750_load_fmt
  import ysyx_22040750_mem_wb_reg_pkg::*;
#(
  parameter int XLEN = MWB_XLEN
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_off,
  input  logic [8:0]      i_rstrb,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_ext;
  logic            w_sign;

  // Byte offset selects which lane lands at bit 0.
  assign w_shifted = i_rdata >> {i_off, 3'b000};

  // Sign bit is the top bit of the highest selected byte.
  always_comb begin
    w_sign = 1'b0;
    case (i_rstrb[7:0])
      RSTRB_B: w_sign = w_shifted[7];
      RSTRB_H: w_sign = w_shifted[15];
      RSTRB_W: w_sign = w_shifted[31];
      RSTRB_D: w_sign = w_shifted[XLEN-1];
      default: w_sign = 1'b0;
    endcase
  end

  // Expand the byte strobe into a bit mask.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_mask[8*i +: 8] = {8{i_rstrb[i]}};
    end
  end

  assign w_ext    = (i_rstrb[RSTRB_SIGN_BIT] && w_sign) ? ~w_mask : '0;
  assign o_result = (w_shifted & w_mask) | w_ext;

endmodule

// File: rtl/ysyx_22040750_mem_wb_reg.sv
// MEM/WB pipeline register. Captures one retiring instruction per cycle,
// formats load data, selects the writeback value and drives regfile/CSR
// write enables, the ID forwarding port and the difftest commit interface.
//
// Handshake: the upstream stage presents I_MEM_WB_valid; a transfer happens
// on a rising edge where I_MEM_WB_valid && O_MEM_WB_allowin. This stage never
// stalls, so O_MEM_WB_allowin is tied high (including during reset).
module ysyx_22040750_mem_wb_reg
  import ysyx_22040750_mem_wb_reg_pkg::*;
#(
  parameter int XLEN = MWB_XLEN,
  parameter int PC_W = MWB_PC_W
) (
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_MEM_WB_valid,
  output logic            O_MEM_WB_allowin,
  input  logic [PC_W-1:0] I_pc,
  input  logic [31:0]     I_inst_debug,
  input  logic            I_bubble_inst_debug,
  input  logic [XLEN-1:0] I_alu_out,
  input  logic [XLEN-1:0] I_mem_rdata,
  input  logic [8:0]      I_rstrb,
  input  logic [1:0]      I_regin_sel,
  input  logic            I_reg_wen,
  input  logic [4:0]      I_rd_addr,
  input  logic [XLEN-1:0] I_csr,
  input  logic [11:0]     I_csr_addr,
  input  logic            I_csr_wen,
  output logic            O_rf_wen,
  output logic [4:0]      O_rf_waddr,
  output logic [XLEN-1:0] O_rf_wdata,
  output logic            O_csr_wen,
  output logic [11:0]     O_csr_addr,
  output logic            O_fwd_valid,
  output logic            O_commit,
  output logic [PC_W-1:0] O_commit_pc,
  output logic [31:0]     O_commit_inst,
  output logic [63:0]     O_retire_cnt
);

  logic            r_valid;
  logic            r_bubble;
  logic            r_reg_wen;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic            r_csr_wen;
  logic [11:0]     r_csr_addr;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [63:0]     r_retire_cnt;

  logic            w_capture;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_wdata;
  logic            w_commit;

  assign O_MEM_WB_allowin = 1'b1;
  assign w_capture        = I_MEM_WB_valid && O_MEM_WB_allowin;

  ysyx_22040750_load_fmt #(
    .XLEN(XLEN)
  ) u_load_fmt (
    .i_rdata (I_mem_rdata),
    .i_off   (I_alu_out[2:0]),
    .i_rstrb (I_rstrb),
    .o_result(w_load)
  );

  // Pick the writeback source ahead of the register.
  always_comb begin
    w_wdata = I_alu_out;
    if (I_regin_sel[REGIN_MEM_BIT]) begin
      w_wdata = w_load;
    end else if (I_regin_sel == REGIN_CSR) begin
      w_wdata = I_csr;
    end
  end

  // Occupancy tracks the upstream valid every cycle (the stage always drains).
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= I_MEM_WB_valid;
    end
  end

  // Payload registers load only on a transfer and hold otherwise.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_bubble   <= 1'b0;
      r_reg_wen  <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_csr_wen  <= 1'b0;
      r_csr_addr <= '0;
      r_pc       <= '0;
      r_inst     <= '0;
    end else if (w_capture) begin
      r_bubble   <= I_bubble_inst_debug;
      r_reg_wen  <= I_reg_wen;
      r_rd       <= I_rd_addr;
      r_wdata    <= w_wdata;
      r_csr_wen  <= I_csr_wen;
      r_csr_addr <= I_csr_addr;
      r_pc       <= I_pc;
      r_inst     <= I_inst_debug;
    end
  end

  // Bubbles occupy the stage but never write or retire; x0 writes are dropped.
  assign w_commit      = r_valid && !r_bubble;
  assign O_rf_wen      = w_commit && r_reg_wen && (r_rd != 5'd0);
  assign O_csr_wen     = w_commit && r_csr_wen;
  assign O_fwd_valid   = O_rf_wen;
  assign O_rf_waddr    = r_rd;
  assign O_rf_wdata    = r_wdata;
  assign O_csr_addr    = r_csr_addr;
  assign O_commit      = w_commit;
  assign O_commit_pc   = r_pc;
  assign O_commit_inst = r_inst;
  assign O_retire_cnt  = r_retire_cnt;

  // Retire counter advances once per commit pulse and wraps naturally.
  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_retire_cnt <= '0;
    end else if (w_commit) begin
      r_retire_cnt <= r_retire_cnt + 64'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_mem_wb_reg.sv
// Bench for the MEM/WB register: directed vector table, randomized
// instructions against a behavioural model, and reset sequences.
module tb_ysyx_22040750_mem_wb_reg;

  logic        I_sys_clk;
  logic        I_rst;
  logic        I_MEM_WB_valid;
  logic        O_MEM_WB_allowin;
  logic [31:0] I_pc;
  logic [31:0] I_inst_debug;
  logic        I_bubble_inst_debug;
  logic [63:0] I_alu_out;
  logic [63:0] I_mem_rdata;
  logic [8:0]  I_rstrb;
  logic [1:0]  I_regin_sel;
  logic        I_reg_wen;
  logic [4:0]  I_rd_addr;
  logic [63:0] I_csr;
  logic [11:0] I_csr_addr;
  logic        I_csr_wen;
  logic        O_rf_wen;
  logic [4:0]  O_rf_waddr;
  logic [63:0] O_rf_wdata;
  logic        O_csr_wen;
  logic [11:0] O_csr_addr;
  logic        O_fwd_valid;
  logic        O_commit;
  logic [31:0] O_commit_pc;
  logic [31:0] O_commit_inst;
  logic [63:0] O_retire_cnt;

  ysyx_22040750_mem_wb_reg dut (
    .I_sys_clk          (I_sys_clk),
    .I_rst              (I_rst),
    .I_MEM_WB_valid     (I_MEM_WB_valid),
    .O_MEM_WB_allowin   (O_MEM_WB_allowin),
    .I_pc               (I_pc),
    .I_inst_debug       (I_inst_debug),
    .I_bubble_inst_debug(I_bubble_inst_debug),
    .I_alu_out          (I_alu_out),
    .I_mem_rdata        (I_mem_rdata),
    .I_rstrb            (I_rstrb),
    .I_regin_sel        (I_regin_sel),
    .I_reg_wen          (I_reg_wen),
    .I_rd_addr          (I_rd_addr),
    .I_csr              (I_csr),
    .I_csr_addr         (I_csr_addr),
    .I_csr_wen          (I_csr_wen),
    .O_rf_wen           (O_rf_wen),
    .O_rf_waddr         (O_rf_waddr),
    .O_rf_wdata         (O_rf_wdata),
    .O_csr_wen          (O_csr_wen),
    .O_csr_addr         (O_csr_addr),
    .O_fwd_valid        (O_fwd_valid),
    .O_commit           (O_commit),
    .O_commit_pc        (O_commit_pc),
    .O_commit_inst      (O_commit_inst),
    .O_retire_cnt       (O_retire_cnt)
  );

  typedef struct {
    logic        valid;
    logic        bubble;
    logic [1:0]  sel;
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [8:0]  rstrb;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] csr;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] exp_wdata;
    logic        exp_rf_wen;
    logic        exp_csr_wen;
    logic        exp_commit;
  } vec_t;

  int          n_vec;
  int          n_err;
  logic [63:0] exp_cnt;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    I_sys_clk = 1'b0;
    forever #5 I_sys_clk = ~I_sys_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural load model: take the named bytes as an unsigned number,
  // then subtract 2^width when a signed value has its top bit set.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                           input int nbytes, input logic sgn);
    logic [63:0] val;
    logic [63:0] lim;
    val = rdata >> (8 * off);
    if (nbytes < 8) begin
      lim = 64'd1 << (8 * nbytes);
      val = val % lim;
      if (sgn && val >= (lim >> 1)) val = val - lim;
    end
    return val;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    I_MEM_WB_valid      = 1'b0;
    I_pc                = '0;
    I_inst_debug        = '0;
    I_bubble_inst_debug = 1'b0;
    I_alu_out           = '0;
    I_mem_rdata         = '0;
    I_rstrb             = '0;
    I_regin_sel         = '0;
    I_reg_wen           = 1'b0;
    I_rd_addr           = '0;
    I_csr               = '0;
    I_csr_addr          = '0;
    I_csr_wen           = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    I_MEM_WB_valid      = v.valid;
    I_pc                = v.pc;
    I_inst_debug        = v.inst;
    I_bubble_inst_debug = v.bubble;
    I_alu_out           = v.alu;
    I_mem_rdata         = v.rdata;
    I_rstrb             = v.rstrb;
    I_regin_sel         = v.sel;
    I_reg_wen           = v.wen;
    I_rd_addr           = v.rd;
    I_csr               = v.csr;
    I_csr_addr          = v.csr_addr;
    I_csr_wen           = v.csr_wen;
  endtask

  // Called at a negedge: drive, let one rising edge capture, check at next negedge.
  task automatic step(input vec_t v);
    logic [63:0] w;
    drive(v);
    if (v.valid) exp_q.push_back(v.exp_wdata);
    @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    check("allowin", {63'd0, O_MEM_WB_allowin}, 64'd1);
    check("retire_cnt", O_retire_cnt, exp_cnt);
    check("commit", {63'd0, O_commit}, {63'd0, v.exp_commit});
    check("rf_wen", {63'd0, O_rf_wen}, {63'd0, v.exp_rf_wen});
    check("fwd_valid", {63'd0, O_fwd_valid}, {63'd0, v.exp_rf_wen});
    check("csr_wen", {63'd0, O_csr_wen}, {63'd0, v.exp_csr_wen});
    if (v.valid) begin
      w = exp_q.pop_front();
      check("rf_wdata", O_rf_wdata, w);
      check("rf_waddr", {59'd0, O_rf_waddr}, {59'd0, v.rd});
      check("csr_addr", {52'd0, O_csr_addr}, {52'd0, v.csr_addr});
      check("commit_pc", {32'd0, O_commit_pc}, {32'd0, v.pc});
      check("commit_inst", {32'd0, O_commit_inst}, {32'd0, v.inst});
    end
    if (v.exp_commit) exp_cnt = exp_cnt + 64'd1;
  endtask

  task automatic do_reset();
    idle_inputs();
    I_rst = 1'b1;
    repeat (2) @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    check("rst_allowin", {63'd0, O_MEM_WB_allowin}, 64'd1);
    check("rst_commit", {63'd0, O_commit}, 64'd0);
    check("rst_rf_wen", {63'd0, O_rf_wen}, 64'd0);
    check("rst_csr_wen", {63'd0, O_csr_wen}, 64'd0);
    check("rst_rf_wdata", O_rf_wdata, 64'd0);
    check("rst_rf_waddr", {59'd0, O_rf_waddr}, 64'd0);
    check("rst_commit_pc", {32'd0, O_commit_pc}, 64'd0);
    check("rst_retire_cnt", O_retire_cnt, 64'd0);
    I_rst   = 1'b0;
    exp_cnt = '0;
    exp_q.delete();
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [63:0] alu,
                              input logic [63:0] rdata, input logic [8:0] rstrb,
                              input logic [4:0] rd, input logic wen, input logic bubble,
                              input logic [63:0] csr, input logic csr_wen,
                              input logic [63:0] exp_wdata, input logic exp_rf_wen,
                              input logic exp_csr_wen, input logic exp_commit);
    vec_t v;
    v.valid = 1'b1;   v.bubble = bubble; v.sel = sel;       v.alu = alu;
    v.rdata = rdata;  v.rstrb = rstrb;   v.rd = rd;         v.wen = wen;
    v.csr = csr;      v.csr_addr = 12'h300; v.csr_wen = csr_wen;
    v.pc = 32'h8000_0000; v.inst = 32'h0000_0013;
    v.exp_wdata = exp_wdata; v.exp_rf_wen = exp_rf_wen;
    v.exp_csr_wen = exp_csr_wen; v.exp_commit = exp_commit;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl[12];

  initial begin
    vec_t v;
    n_vec   = 0;
    n_err   = 0;
    exp_cnt = '0;
    I_rst   = 1'b1;
    idle_inputs();

    //          sel    alu                    rdata                  rstrb   rd  wen bub csr       cwen exp_wdata              rfw cw  cm
    tbl[0]  = mk(2'b00, 64'h1234,              64'h0,                 9'h000, 5,  1,  0,  64'h0,    0,   64'h1234,              1,  0,  1);
    tbl[1]  = mk(2'b10, 64'h1001,              64'h0080_FF00,         9'h101, 6,  1,  0,  64'h0,    0,   64'hFFFF_FFFF_FFFF_FFFF, 1,  0,  1);
    tbl[2]  = mk(2'b10, 64'h1002,              64'h0080_FF00,         9'h001, 7,  1,  0,  64'h0,    0,   64'h80,                1,  0,  1);
    tbl[3]  = mk(2'b10, 64'h1002,              64'h0080_FF00,         9'h101, 8,  1,  0,  64'h0,    0,   64'hFFFF_FFFF_FFFF_FF80, 1,  0,  1);
    tbl[4]  = mk(2'b11, 64'h2004,              64'h8000_0000_0000_0000, 9'h10F, 9, 1,  0,  64'h0,    0,   64'hFFFF_FFFF_8000_0000, 1,  0,  1);
    tbl[5]  = mk(2'b10, 64'h2004,              64'h8000_0000_0000_0000, 9'h00F, 10, 1, 0,  64'h0,    0,   64'h0000_0000_8000_0000, 1,  0,  1);
    tbl[6]  = mk(2'b10, 64'h3002,              64'h0000_0000_8001_0000, 9'h103, 11, 1, 0,  64'h0,    0,   64'hFFFF_FFFF_FFFF_8001, 1,  0,  1);
    tbl[7]  = mk(2'b10, 64'h3000,              64'h8765_4321_0FED_CBA9, 9'h1FF, 12, 1, 0,  64'h0,    0,   64'h8765_4321_0FED_CBA9, 1,  0,  1);
    tbl[8]  = mk(2'b00, 64'h55,                64'h0,                 9'h000, 0,  1,  0,  64'h0,    0,   64'h55,                0,  0,  1);
    tbl[9]  = mk(2'b00, 64'h66,                64'h0,                 9'h000, 13, 1,  1,  64'h0,    1,   64'h66,                0,  0,  0);
    tbl[10] = mk(2'b01, 64'h77,                64'h0,                 9'h000, 14, 1,  0,  64'hDEAD, 1,   64'hDEAD,              1,  1,  1);
    tbl[11] = mk(2'b00, 64'h88,                64'h0,                 9'h000, 15, 1,  0,  64'h0,    0,   64'h0,                 0,  0,  0);
    tbl[11].valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tbl[i].pc   = 32'h8000_0000 + 32'(4 * i);
      tbl[i].inst = 32'h0010_0093 + 32'(i);
    end

    do_reset();
    for (int i = 0; i < 12; i++) step(tbl[i]);

    // Four back-to-back ALU ops then a CSR op: five consecutive commits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = mk(2'b00, 64'(100 + i), 64'h0, 9'h000, 5'(i + 1), 1, 0, 64'h0, 0, 64'(100 + i), 1, 0, 1);
      v.pc = 32'h8000_1000 + 32'(4 * i);
      step(v);
    end
    v = mk(2'b01, 64'h0, 64'h0, 9'h000, 5'd20, 1, 0, 64'hDEAD, 1, 64'hDEAD, 1, 1, 1);
    step(v);
    v = tbl[11];
    step(v);
    check("cnt_after_five", O_retire_cnt, 64'd5);

    // Reset arriving with an instruction on the input: nothing captured, no pulse.
    v = mk(2'b00, 64'h99, 64'h0, 9'h000, 5'd3, 1, 0, 64'h0, 0, 64'h99, 1, 0, 1);
    drive(v);
    I_rst = 1'b1;
    @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    check("midrst_commit", {63'd0, O_commit}, 64'd0);
    check("midrst_rf_wen", {63'd0, O_rf_wen}, 64'd0);
    check("midrst_cnt", O_retire_cnt, 64'd0);
    I_rst   = 1'b0;
    exp_cnt = '0;
    exp_q.delete();
    idle_inputs();

    // Randomized instructions against the behavioural model.
    for (int n = 0; n < 300; n++) begin
      int nbytes;
      int off;
      logic sgn;
      logic [63:0] load_val;
      nbytes = 1 << $urandom_range(0, 3);
      off    = $urandom_range(0, (8 / nbytes) - 1) * nbytes;
      sgn    = 1'($urandom_range(0, 1));
      v.valid    = ($urandom_range(0, 7) != 0);
      v.bubble   = ($urandom_range(0, 7) == 0);
      v.sel      = 2'($urandom_range(0, 3));
      v.alu      = {$urandom, $urandom};
      v.alu[2:0] = 3'(off);
      v.rdata    = {$urandom, $urandom};
      v.rstrb    = {sgn, 8'((1 << nbytes) - 1)};
      v.rd       = 5'($urandom_range(0, 31));
      v.wen      = 1'($urandom_range(0, 1));
      v.csr      = {$urandom, $urandom};
      v.csr_addr = 12'($urandom);
      v.csr_wen  = 1'($urandom_range(0, 1));
      v.pc       = $urandom;
      v.inst     = $urandom;
      load_val   = ref_load(v.rdata, off, nbytes, sgn);
      if (v.sel >= 2) v.exp_wdata = load_val;
      else if (v.sel == 1) v.exp_wdata = v.csr;
      else v.exp_wdata = v.alu;
      v.exp_commit  = v.valid && !v.bubble;
      v.exp_rf_wen  = v.exp_commit && v.wen && (v.rd != 0);
      v.exp_csr_wen = v.exp_commit && v.csr_wen;
      step(v);
    end
    idle_inputs();
    @(posedge I_sys_clk);
    @(negedge I_sys_clk);
    check("final_cnt", O_retire_cnt, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
